// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: widths, read/write encoding and
// the handshake state machine states.
package mips_mem_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 9;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ram_state_e;

endpackage

// File: rtl/mips_ram.sv
// Byte-wide data memory for the MIPS datapath with a level-based Enable/MOC
// handshake; one operation in flight at a time, MOV marks fresh read data.
module mips_ram
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = RAM_ADDR_WIDTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  MOC,
  input  logic                  Enable,
  output logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn
);

  // The counter runs down through zero, so BUSY spans WAIT_CYCLES+1 edges and
  // MOC rises WAIT_CYCLES+1 edges after the accepting edge.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  reg [DATA_WIDTH-1:0] Mem [0:2**ADDR_WIDTH-1];

  ram_state_e            state_r;
  logic [3:0]            cnt_r;
  logic                  rw_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] din_r;
  logic                  commit_s;

  // Access happens on the edge where BUSY sees an exhausted counter.
  always_comb begin
    commit_s = 1'b0;
    if ((state_r == BUSY) && (cnt_r == 4'd0)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Storage write port; not reset, and reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (commit_s && (rw_r == RW_WRITE)) begin
      Mem[addr_r] <= din_r;
    end
  end

  // Handshake FSM, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= 1'b0;
      addr_r  <= '0;
      din_r   <= '0;
      DataOut <= '0;
      MOC     <= 1'b0;
      MOV     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          MOC <= 1'b0;
          MOV <= 1'b0;
          if (Enable) begin
            rw_r    <= ReadWrite;
            addr_r  <= Address;
            din_r   <= DataIn;
            cnt_r   <= CNT_LOAD;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r == 4'd0) begin
            MOC <= 1'b1;
            if (rw_r == RW_READ) begin
              DataOut <= Mem[addr_r];
              MOV     <= 1'b1;
            end else begin
              MOV <= 1'b0;
            end
            // Enable already gone: pulse MOC/MOV for one cycle via IDLE.
            state_r <= Enable ? DONE : IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          if (!Enable) begin
            MOC     <= 1'b0;
            MOV     <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          MOC     <= 1'b0;
          MOV     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ram.sv
// Directed bench for mips_ram: table of read/write operations plus hand-written
// sequences for reset abort, early Enable drop, input stability and a slow build.
module tb_mips_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] DataOut, DataOut4;
  logic       MOC, MOV, MOC4, MOV4;
  logic       Enable, ReadWrite, Enable4, ReadWrite4;
  logic [8:0] Address, Address4;
  logic [7:0] DataIn, DataIn4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_ram dut (
    .clk(clk), .rst_n(rst_n), .DataOut(DataOut), .MOC(MOC), .Enable(Enable),
    .MOV(MOV), .ReadWrite(ReadWrite), .Address(Address), .DataIn(DataIn)
  );

  mips_ram #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .DataOut(DataOut4), .MOC(MOC4), .Enable(Enable4),
    .MOV(MOV4), .ReadWrite(ReadWrite4), .Address(Address4), .DataIn(DataIn4)
  );

  typedef struct {
    logic       rw;
    logic [8:0] addr;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_mov;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for MOC on the default-latency instance, returning edges since accept.
  task automatic wait_moc(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (MOC) break;
    end
  endtask

  // One operation with Enable held 5 cycles from the accepting edge.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    ReadWrite = v.rw; Address = v.addr; DataIn = v.din; Enable = 1'b1;
    @(posedge clk);
    wait_moc(lat);
    chk($sformatf("lat[%0d]", idx), lat, 2);
    chk($sformatf("dout[%0d]", idx), DataOut, v.exp_d);
    chk($sformatf("mov[%0d]", idx), MOV, v.exp_mov);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("moc_hold[%0d]", idx), MOC, 1);
    @(negedge clk);
    Enable = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("moc_drop[%0d]", idx), {MOC, MOV}, 2'b00);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; Enable = 1'b0; ReadWrite = 1'b1; Address = '0; DataIn = '0;
    Enable4 = 1'b0; ReadWrite4 = 1'b1; Address4 = '0; DataIn4 = '0;
    for (int i = 0; i < 10; i++) dut.Mem[i] = 8'(10 * (i + 1));
    dut.Mem[5] = 8'd60;
    dut4.Mem[6] = 8'h66;

    for (int i = 0; i < 10; i++)
      vecs[i] = '{rw: 1'b1, addr: 9'(i), din: 8'h00, exp_d: 8'(10 * (i + 1)), exp_mov: 1'b1};
    vecs[10] = '{rw: 1'b0, addr: 9'd511, din: 8'hA5, exp_d: 8'd100, exp_mov: 1'b0};
    vecs[11] = '{rw: 1'b1, addr: 9'd511, din: 8'h00, exp_d: 8'hA5, exp_mov: 1'b1};

    #12;
    chk("rst_out", {DataOut, MOC, MOV}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    // Early Enable drop on a write: one-cycle MOC pulse, write still lands.
    @(negedge clk);
    ReadWrite = 1'b0; Address = 9'd7; DataIn = 8'h3C; Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Enable = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (MOC) break;
    end
    chk("early_lat", lat, 2);
    chk("early_mov", MOV, 0);
    @(posedge clk); #1;
    chk("early_moc_drop", MOC, 0);
    chk("early_mem", dut.Mem[7], 8'h3C);
    @(posedge clk); #1;
    chk("early_moc_stay", MOC, 0);

    // Back in IDLE: a fresh read of addr 7 is accepted with normal latency.
    run_op('{rw: 1'b1, addr: 9'd7, din: 8'h00, exp_d: 8'h3C, exp_mov: 1'b1}, 20);

    // Address changes after acceptance are ignored.
    @(negedge clk);
    ReadWrite = 1'b1; Address = 9'd2; Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Address = 9'd3; ReadWrite = 1'b0; DataIn = 8'hEE;
    wait_moc(lat);
    chk("stable_dout", DataOut, 8'd30);
    chk("stable_mov", MOV, 1);
    @(negedge clk);
    Enable = 1'b0;
    @(posedge clk); #1;
    chk("stable_mem3", dut.Mem[3], 8'd40);

    // Reset mid-BUSY aborts a pending write to addr 5.
    @(negedge clk);
    ReadWrite = 1'b0; Address = 9'd5; DataIn = 8'h77; Enable = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    Enable = 1'b0;
    #1;
    chk("abort_out", {DataOut, MOC, MOV}, 10'h000);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_mem5", dut.Mem[5], 8'd60);
    chk("abort_moc", MOC, 0);

    // Slow instance: MOC five edges after accept, low on every edge before.
    @(negedge clk);
    ReadWrite4 = 1'b1; Address4 = 9'd6; Enable4 = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (MOC4) break;
    end
    chk("w4_lat", lat, 5);
    chk("w4_dout", DataOut4, 8'h66);
    chk("w4_mov", MOV4, 1);
    @(negedge clk);
    Enable4 = 1'b0;
    @(posedge clk); #1;
    chk("w4_drop", {MOC4, MOV4}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
